// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the elastic pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Encodings double as the occupancy count of each state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stage_state_t;

    localparam int OCC_W = 2;

    // ID/EX decoder control field defaults.
    localparam int                      ID_EX_CTRL_W      = 15;
    localparam logic [ID_EX_CTRL_W-1:0] ID_EX_BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/pipeline_stage_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_slot
// Description : One payload+control holding register, load enable, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_slot #(
    parameter int W = 47
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stage_elastic
// Description : Valid/ready pipeline stage register with optional skid slot
//               and bubble-forced control field.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = ID_EX_CTRL_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(ID_EX_BUBBLE_CTRL),
    parameter int                SKID_EN     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CTRL_W-1:0] dn_ctrl_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    localparam int c_slot_w = DATA_W + CTRL_W;

    stage_state_t        r_state;
    stage_state_t        w_state_nxt;
    logic                w_up_ready;
    logic                w_up_fire;
    logic                w_dn_fire;
    logic                w_main_load;
    logic                w_main_from_skid;
    logic                w_skid_load;
    logic [c_slot_w-1:0] w_up_slot;
    logic [c_slot_w-1:0] w_main_d;
    logic [c_slot_w-1:0] w_main_q;
    logic [c_slot_w-1:0] w_skid_q;

    assign w_up_slot  = {up_ctrl_i, up_data_i};
    assign dn_valid_o = (r_state != EMPTY);
    assign w_up_fire  = up_valid_i & w_up_ready;
    assign w_dn_fire  = dn_valid_o & dn_ready_i;
    assign up_ready_o = w_up_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_up_fire) begin
                    w_main_load = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (w_up_fire && w_dn_fire) begin
                    w_main_load = 1'b1;
                end else if (w_dn_fire) begin
                    w_state_nxt = EMPTY;
                end else if (w_up_fire && (SKID_EN != 0)) begin
                    w_skid_load = 1'b1;
                    w_state_nxt = SKID;
                end
            end
            SKID: begin
                if (dn_ready_i) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = FULL;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush drops held and incoming beats; slot contents are left as-is.
        if (flush_i) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_up_slot;

    pipeline_stage_slot #(
        .W (c_slot_w)
    ) u_main (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            // Ready is registered so stalls never ripple combinationally upstream.
            logic r_up_ready;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_up_ready <= 1'b1;
                end else begin
                    r_up_ready <= (w_state_nxt != SKID);
                end
            end

            assign w_up_ready = r_up_ready;

            pipeline_stage_slot #(
                .W (c_slot_w)
            ) u_skid (
                .clk    (clk_i),
                .rst    (rst_i),
                .i_load (w_skid_load),
                .i_d    (w_up_slot),
                .o_q    (w_skid_q)
            );
        end else begin : g_no_skid
            assign w_up_ready = dn_ready_i | ~dn_valid_o;
            assign w_skid_q   = '0;
        end
    endgenerate

    assign dn_data_o = w_main_q[DATA_W-1:0];
    assign dn_ctrl_o = dn_valid_o ? w_main_q[c_slot_w-1:DATA_W] : BUBBLE_CTRL;

    always_comb begin
        occupancy_o = '0;
        case (r_state)
            FULL:    occupancy_o = OCC_W'(1);
            SKID:    occupancy_o = OCC_W'(2);
            default: occupancy_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stage_elastic
// Description : Self-checking bench for both skid and no-skid stage variants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_elastic;

    localparam logic [14:0] c_bubble = 15'h2AC3;

    logic             clk;
    logic [1:0]       rst, flush, uv, ur, dv, dr;
    logic [1:0][31:0] ud, dd;
    logic [1:0][14:0] uc, dc;
    logic [1:0][1:0]  occ;
    logic [1:0]       fire_up;
    logic             sb_en;
    int               nvec, nfail;
    int               seq [2];
    logic [46:0]      q0 [$];
    logic [46:0]      q1 [$];

    // Index 1: skid variant, index 0: single-slot variant.
    pipeline_stage_elastic #(
        .DATA_W (32), .CTRL_W (15), .BUBBLE_CTRL (c_bubble), .SKID_EN (1)
    ) dut_skid (
        .clk_i (clk), .rst_i (rst[1]), .flush_i (flush[1]),
        .up_valid_i (uv[1]), .up_ready_o (ur[1]), .up_data_i (ud[1]), .up_ctrl_i (uc[1]),
        .dn_valid_o (dv[1]), .dn_ready_i (dr[1]), .dn_data_o (dd[1]), .dn_ctrl_o (dc[1]),
        .occupancy_o (occ[1])
    );

    pipeline_stage_elastic #(
        .DATA_W (32), .CTRL_W (15), .BUBBLE_CTRL (c_bubble), .SKID_EN (0)
    ) dut_single (
        .clk_i (clk), .rst_i (rst[0]), .flush_i (flush[0]),
        .up_valid_i (uv[0]), .up_ready_o (ur[0]), .up_data_i (ud[0]), .up_ctrl_i (uc[0]),
        .dn_valid_o (dv[0]), .dn_ready_i (dr[0]), .dn_data_o (dd[0]), .dn_ctrl_o (dc[0]),
        .occupancy_o (occ[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ctrl_of(input logic [31:0] d);
        return d[14:0] ^ 15'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [46:0] q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic q_push(input int k, input logic [46:0] v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    task automatic q_clear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    // Scoreboard: checks the held state each cycle, then advances the model
    // by what the coming edge will transfer.
    always @(negedge clk) begin
        if (sb_en) begin
            for (int k = 0; k < 2; k++) begin
                int          sz;
                logic        exp_ur;
                logic        dn_fire;
                logic [46:0] f;
                sz     = q_size(k);
                exp_ur = (k == 1) ? (sz < 2) : (dr[k] || (sz == 0));
                chk($sformatf("sb%0d dn_valid", k), 64'(dv[k]), 64'(sz != 0));
                chk($sformatf("sb%0d occupancy", k), 64'(occ[k]), 64'(sz));
                chk($sformatf("sb%0d up_ready", k), 64'(ur[k]), 64'(exp_ur));
                if (sz != 0) begin
                    f = q_front(k);
                    chk($sformatf("sb%0d dn_data", k), 64'(dd[k]), 64'(f[31:0]));
                    chk($sformatf("sb%0d dn_ctrl", k), 64'(dc[k]), 64'(f[46:32]));
                end else begin
                    chk($sformatf("sb%0d bubble", k), 64'(dc[k]), 64'(c_bubble));
                end
                dn_fire    = (sz != 0) && dr[k];
                fire_up[k] = uv[k] && exp_ur;
                if (rst[k] || flush[k]) begin
                    q_clear(k);
                end else begin
                    if (dn_fire) q_pop(k);
                    if (fire_up[k]) q_push(k, {uc[k], ud[k]});
                end
            end
        end
    end

    typedef struct packed {
        logic        inst;
        logic        rst;
        logic        flush;
        logic        uv;
        logic [31:0] ud;
        logic        dr;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        er;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t row(input logic inst, input logic r, input logic fl,
                                 input logic v, input logic [31:0] d, input logic rdy,
                                 input logic ev, input logic [31:0] ed,
                                 input logic [1:0] eo, input logic er);
        vec_t t;
        t.inst = inst; t.rst = r; t.flush = fl; t.uv = v; t.ud = d; t.dr = rdy;
        t.ev = ev; t.ed = ed; t.eo = eo; t.er = er;
        return t;
    endfunction

    task automatic idle_inputs();
        rst = '0; flush = '0; uv = '0; dr = '1;
        for (int k = 0; k < 2; k++) begin
            ud[k] = '0;
            uc[k] = ctrl_of(32'h0);
        end
    endtask

    initial begin
        nvec = 0; nfail = 0; sb_en = 1'b0; fire_up = '0;
        seq[0] = 0; seq[1] = 0;

        //            inst rst fl uv data     dr | ev exp_data  occ ur
        tbl[0]  = row(1, 0, 0, 1, 32'h11, 1,  0, 32'h00, 0, 1);
        tbl[1]  = row(1, 0, 0, 1, 32'h22, 1,  1, 32'h11, 1, 1);
        tbl[2]  = row(1, 0, 0, 1, 32'h33, 1,  1, 32'h22, 1, 1);
        tbl[3]  = row(1, 0, 0, 0, 32'h00, 1,  1, 32'h33, 1, 1);
        tbl[4]  = row(1, 0, 0, 0, 32'h00, 1,  0, 32'h33, 0, 1);
        tbl[5]  = row(1, 0, 0, 1, 32'hA0, 1,  0, 32'h33, 0, 1);
        tbl[6]  = row(1, 0, 0, 1, 32'hB0, 0,  1, 32'hA0, 1, 1);
        tbl[7]  = row(1, 0, 0, 0, 32'h00, 0,  1, 32'hA0, 2, 0);
        tbl[8]  = row(1, 0, 0, 0, 32'h00, 1,  1, 32'hA0, 2, 0);
        tbl[9]  = row(1, 0, 0, 0, 32'h00, 1,  1, 32'hB0, 1, 1);
        tbl[10] = row(1, 0, 0, 0, 32'h00, 1,  0, 32'hB0, 0, 1);
        tbl[11] = row(1, 0, 0, 1, 32'hD1, 0,  0, 32'hB0, 0, 1);
        tbl[12] = row(1, 0, 0, 1, 32'hD2, 0,  1, 32'hD1, 1, 1);
        tbl[13] = row(1, 0, 1, 1, 32'hC0, 0,  1, 32'hD1, 2, 0);
        tbl[14] = row(1, 0, 0, 1, 32'hE1, 0,  0, 32'hD1, 0, 1);
        tbl[15] = row(1, 0, 1, 1, 32'hC0, 1,  1, 32'hE1, 1, 1);
        tbl[16] = row(1, 0, 0, 0, 32'h00, 1,  0, 32'hE1, 0, 1);
        tbl[17] = row(1, 0, 0, 1, 32'hF1, 0,  0, 32'hE1, 0, 1);
        tbl[18] = row(1, 1, 1, 1, 32'hF2, 0,  1, 32'hF1, 1, 1);
        tbl[19] = row(1, 0, 0, 0, 32'h00, 0,  0, 32'h00, 0, 1);
        tbl[20] = row(0, 0, 0, 1, 32'h55, 0,  0, 32'h00, 0, 1);
        tbl[21] = row(0, 0, 0, 1, 32'h66, 0,  1, 32'h55, 1, 0);
        tbl[22] = row(0, 0, 0, 1, 32'h66, 1,  1, 32'h55, 1, 1);
        tbl[23] = row(0, 0, 0, 0, 32'h00, 1,  1, 32'h66, 1, 1);
        tbl[24] = row(0, 0, 0, 0, 32'h00, 0,  0, 32'h66, 0, 1);

        idle_inputs();
        rst = '1;
        repeat (3) @(posedge clk);
        #1;
        rst   = '0;
        sb_en = 1'b1;

        for (int i = 0; i < 25; i++) begin
            int k;
            @(posedge clk);
            #1;
            idle_inputs();
            k        = int'(tbl[i].inst);
            rst[k]   = tbl[i].rst;
            flush[k] = tbl[i].flush;
            uv[k]    = tbl[i].uv;
            ud[k]    = tbl[i].ud;
            uc[k]    = ctrl_of(tbl[i].ud);
            dr[k]    = tbl[i].dr;
            @(negedge clk);
            chk($sformatf("row%0d dn_valid", i), 64'(dv[k]), 64'(tbl[i].ev));
            chk($sformatf("row%0d dn_data", i), 64'(dd[k]), 64'(tbl[i].ed));
            chk($sformatf("row%0d dn_ctrl", i), 64'(dc[k]),
                64'(tbl[i].ev ? ctrl_of(tbl[i].ed) : c_bubble));
            chk($sformatf("row%0d occupancy", i), 64'(occ[k]), 64'(tbl[i].eo));
            chk($sformatf("row%0d up_ready", i), 64'(ur[k]), 64'(tbl[i].er));
        end

        // Random traffic; upstream holds its beat until it is taken.
        for (int n = 0; n < 10000; n++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                rst[k]   = 1'b0;
                flush[k] = ($urandom_range(0, 63) == 0);
                dr[k]    = ($urandom_range(0, 2) != 0);
                if (!(uv[k] && !fire_up[k])) begin
                    uv[k]  = ($urandom_range(0, 3) != 0);
                    seq[k] = seq[k] + 1;
                    ud[k]  = {8'(k), 24'(seq[k])};
                    uc[k]  = ctrl_of(ud[k]);
                end
            end
        end

        @(posedge clk);
        #1;
        uv = '0; flush = '0; dr = '1;
        repeat (6) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_stage_elastic.md
# pipeline_stage_elastic

Parametrised elastic pipeline stage register; next generation of the fixed keep/clear stage registers between pipeline stages. It carries an arbitrary-width data payload plus a control field that is forced to a bubble (NOP) encoding whenever the stage holds no valid beat. It replaces keep/clear with a valid/ready handshake and an optional skid slot, so stalls need no combinational ready path back through the pipeline. It sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- DATA_W, 32: width of the payload (operands, PC+4, immediates, register indices).
- CTRL_W, 15: width of the decoder control field.
- BUBBLE_CTRL, 0: control value presented when the stage holds no valid beat.
- SKID_EN, 1: 1 gives a two-slot skid buffer with registered up_ready_o; 0 gives a single slot with combinational up_ready_o.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all held beats (branch mispredict or exception).
- up_valid_i  in  1  upstream beat valid.
- up_ready_o  out  1  stage can accept a beat.
- up_data_i  in  DATA_W  upstream payload.
- up_ctrl_i  in  CTRL_W  upstream control field.
- dn_valid_o  out  1  downstream beat valid.
- dn_ready_i  in  1  downstream accepts.
- dn_data_o  out  DATA_W  payload of the main slot.
- dn_ctrl_o  out  CTRL_W  control of the main slot, or BUBBLE_CTRL when dn_valid_o=0.
- occupancy_o  out  2  number of held beats (0..2).

## Operation
- A transfer occurs on an edge where valid and ready are both high. Upstream must hold data and control stable while up_valid_i=1 and up_ready_o=0.
- There are two slots: main (drives dn_*) and skid. Skid exists only when SKID_EN=1.
- FSM states (SKID_EN=1): EMPTY, FULL, SKID.
  - EMPTY: up_ready_o=1. On up_valid_i, load main and go to FULL.
  - FULL:
    - up_ready_o=1.
    - up_valid_i and dn_ready_i: reload main, stay FULL.
    - dn_ready_i only: go to EMPTY.
    - up_valid_i only: load skid, go to SKID.
  - SKID: up_ready_o=0. On dn_ready_i, copy skid to main and go to FULL.
- In SKID_EN=1, up_ready_o is a register output equal to (state != SKID).
- SKID_EN=0: states are EMPTY and FULL only. up_ready_o = dn_ready_i | ~dn_valid_o. SKID is unreachable.
- flush_i has top priority. Next state is EMPTY. Any beat accepted upstream in the same cycle is dropped. Slot data registers keep their contents; only the valid state clears.
- rst_i has the same effect as flush_i, and also clears both data slots and control slots to 0.
- dn_ctrl_o = BUBBLE_CTRL whenever dn_valid_o=0, so a downstream stage that ignores valid still sees a NOP.
- occupancy_o: EMPTY=0, FULL=1, SKID=2.
- rst_i and flush_i in the same cycle: reset behaviour applies.

## Timing
- Values after reset: dn_valid_o=0, dn_ctrl_o=BUBBLE_CTRL, dn_data_o=0, occupancy_o=0, up_ready_o=1.
- Latency: a beat accepted at edge N appears on dn_* after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle sustained while dn_ready_i=1.
- After a flush at edge N: dn_valid_o=0 in cycle N+1, and a new beat can be accepted at edge N+1.
- SKID_EN=1: no combinational path from dn_ready_i to up_ready_o. After dn_ready_i falls, at most one extra beat is absorbed.
- SKID_EN=1: ready recovers one cycle after the skid drains, i.e. up_ready_o=1 in the cycle after the SKID→FULL edge.
- dn_ctrl_o and dn_valid_o come from the same registered state; there is no glitching between them.

## Structure
- Shared package pipe_pkg:
  - stage_state_t enum (EMPTY, FULL, SKID).
  - OCC_W=2.
  - Default CTRL_W and BUBBLE_CTRL constants for the ID/EX decoder field.
- One sub-module: pipeline_stage_slot.
  - A DATA_W+CTRL_W register with a load enable and synchronous clear.
  - Instantiated as main and, under a generate on SKID_EN, as skid.
- FSM and muxing live in the top module.

## Test plan
- Reset, then stream 0x11,0x22,0x33 with dn_ready_i=1 → dn_data_o shows 0x11,0x22,0x33 on consecutive cycles, one cycle behind input; occupancy_o stays at 1.
- SKID_EN=1, main holds 0xA0, dn_ready_i drops while 0xB0 is offered → occupancy_o=2 and up_ready_o=0 next cycle. Raise dn_ready_i → 0xA0 then 0xB0 delivered, none lost or duplicated.
- SKID state plus flush_i with up_valid_i=1 (0xC0) → next cycle dn_valid_o=0, dn_ctrl_o=BUBBLE_CTRL, occupancy_o=0. 0xC0 never appears downstream.
- SKID_EN=0, FULL, dn_ready_i=0 → up_ready_o=0 in the same cycle; dn_ready_i=1 → up_ready_o=1 in the same cycle.
- rst_i asserted mid-stream with flush_i also high → all outputs at reset values the next cycle, dn_data_o=0.
- Random valid/ready (10k cycles, both SKID_EN values) → scoreboard checks order, no loss or duplication, and dn_ctrl_o=BUBBLE_CTRL whenever dn_valid_o=0.
